// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial sequencer sharing one synchronous byte-wide RAM between fetch and load/store.
// Define MEM_CTRL_FETCH_BUF_EN to add a one-entry fetch buffer that skips RAM for repeated fetches.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              flush_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  // Handshake: if_req_i / mem_req_i are levels sampled only in IDLE (MEM wins); the
  // access is accepted at that edge and ends with a one-cycle *_done_o pulse, during
  // which the requester must drop or refresh its request.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        owner_mem;
  logic [2:0]  k, len_n, req_n;
  logic [31:0] base, wdata, asm_data, rd_word, addr_nxt, req_addr;
  logic [7:0]  wr_byte;
  logic        buf_hit;
  logic [31:0] buf_word;
  logic        unused_addr;

  always_comb begin
    req_n = 3'd4;
    if (mem_req_i) begin
      case (mem_len_i)
        2'd0:    req_n = 3'd1;
        2'd1:    req_n = 3'd2;
        default: req_n = 3'd4;
      endcase
    end
  end

  assign req_addr    = mem_req_i ? mem_addr_i : if_addr_i;
  assign addr_nxt    = base + {29'd0, k} + 32'd1;
  assign unused_addr = ^addr_nxt[31:ADDR_W];

  // In RD cycle k the RAM returns byte k-1 (address issued the cycle before).
  always_comb begin
    rd_word = asm_data;
    if (state == RD) begin
      case (k)
        3'd1:    rd_word[7:0]   = ram_din_i;
        3'd2:    rd_word[15:8]  = ram_din_i;
        3'd3:    rd_word[23:16] = ram_din_i;
        3'd4:    rd_word[31:24] = ram_din_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (k)
      3'd0:    wr_byte = wdata[15:8];
      3'd1:    wr_byte = wdata[23:16];
      default: wr_byte = wdata[31:24];
    endcase
  end

`ifdef MEM_CTRL_FETCH_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_addr;

  assign buf_hit = buf_valid && (buf_addr == if_addr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_word  <= '0;
    end else if (state == IDLE && mem_req_i && mem_we_i) begin
      buf_valid <= 1'b0;
    end else if (state == DONE && !owner_mem && !flush_i) begin
      buf_valid <= 1'b1;
      buf_addr  <= base;
      buf_word  <= if_data_o;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req_i)     state_nxt = mem_we_i ? WR : RD;
        else if (if_req_i) state_nxt = buf_hit ? DONE : RD;
      end
      RD: begin
        if (!owner_mem && flush_i) state_nxt = IDLE;
        else if (k == len_n)       state_nxt = DONE;
      end
      WR: begin
        if (k + 3'd1 == len_n) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_done_o  = (state == DONE) && !owner_mem && !flush_i;
  assign mem_done_o = (state == DONE) && owner_mem;
  assign stallreq_o = mem_req_i & ~mem_done_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem   <= 1'b0;
      k           <= 3'd0;
      len_n       <= 3'd0;
      base        <= '0;
      wdata       <= '0;
      asm_data    <= '0;
      if_data_o   <= '0;
      mem_rdata_o <= '0;
      ram_a_o     <= '0;
      ram_dout_o  <= '0;
      ram_wr_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k <= 3'd0;
          if (mem_req_i || if_req_i) begin
            owner_mem <= mem_req_i;
            base      <= req_addr;
            wdata     <= mem_wdata_i;
            len_n     <= req_n;
            asm_data  <= '0;
            if (!mem_req_i && buf_hit) begin
              if_data_o <= buf_word;
            end else begin
              ram_a_o    <= req_addr[ADDR_W-1:0];
              ram_dout_o <= mem_wdata_i[7:0];
              ram_wr_o   <= mem_req_i && mem_we_i;
            end
          end
        end
        RD: begin
          k        <= k + 3'd1;
          asm_data <= rd_word;
          if (k + 3'd1 < len_n) ram_a_o <= addr_nxt[ADDR_W-1:0];
          if (state_nxt == DONE) begin
            if (owner_mem) mem_rdata_o <= rd_word;
            else           if_data_o   <= rd_word;
          end
        end
        WR: begin
          k <= k + 3'd1;
          if (k + 3'd1 < len_n) begin
            ram_a_o    <= addr_nxt[ADDR_W-1:0];
            ram_dout_o <= wr_byte;
          end else begin
            ram_wr_o <= 1'b0;
          end
        end
        default: k <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized bench for mem_ctrl; a byte-array reference memory and
// per-transaction latency/data expectations act as the scoreboard.
module tb_mem_ctrl;
  localparam int ADDR_W = 17;
  localparam int MSIZE  = 1 << ADDR_W;
  localparam logic [31:0] MASK = 32'(MSIZE - 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_ram = 1'b0;
  logic              if_req_i = 1'b0;
  logic [31:0]       if_addr_i = '0;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              flush_i = 1'b0;
  logic              mem_req_i = 1'b0;
  logic              mem_we_i = 1'b0;
  logic [1:0]        mem_len_i = '0;
  logic [31:0]       mem_addr_i = '0;
  logic [31:0]       mem_wdata_i = '0;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  logic              stallreq_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;
  logic [7:0]        ram_din_i;

  logic [7:0]  ram     [MSIZE];
  logic [7:0]  ref_mem [MSIZE];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_mem = '0;
  bit          buf_v = 1'b0;
  logic [31:0] buf_a = '0;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .flush_i(flush_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .stallreq_o(stallreq_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Synchronous byte RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < MSIZE; i++) ram[i] <= ref_mem[i];
    end else if (ram_wr_o) begin
      ram[ram_a_o] <= ram_dout_o;
    end
    ram_din_i <= ram[ram_a_o];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[ADDR_W'(a + 32'(i))];
    return w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_if_data"}, if_data_o, 32'h0);
    check({tag, "_if_done"}, 32'(if_done_o), 32'h0);
    check({tag, "_mem_rdata"}, mem_rdata_o, 32'h0);
    check({tag, "_mem_done"}, 32'(mem_done_o), 32'h0);
    check({tag, "_stall"}, 32'(stallreq_o), 32'h0);
    check({tag, "_ram_a"}, 32'(ram_a_o), 32'h0);
    check({tag, "_ram_dout"}, 32'(ram_dout_o), 32'h0);
    check({tag, "_ram_wr"}, 32'(ram_wr_o), 32'h0);
  endtask

  // driver: one fetch, optionally redirected in cycle flush_at (counted from request)
  task automatic do_fetch(input logic [31:0] a, input int flush_at);
    int cnt, n_done, exp_lat;
    bit seen, flushed, hit;
    logic [31:0] exp_w;
    hit = 1'b0;
`ifdef MEM_CTRL_FETCH_BUF_EN
    hit = buf_v && (buf_a == a);
`endif
    exp_lat = hit ? 2 : 7;
    exp_w = ref_word(a, 4);
    cnt = 0; n_done = 0; seen = 1'b0; flushed = 1'b0;
    @(posedge clk); #1;
    if_addr_i = a;
    if_req_i  = 1'b1;
    while (!seen && !flushed && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (!hit && cnt >= 2 && cnt <= 5) begin
        check("fetch_ram_a", 32'(ram_a_o), (a + 32'(cnt - 2)) & MASK);
        check("fetch_ram_wr", 32'(ram_wr_o), 32'h0);
      end
      if (if_done_o) begin
        seen = 1'b1;
      end else if (cnt == flush_at) begin
        flush_i  = 1'b1;
        if_req_i = 1'b0;
        flushed  = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
      end
    end
    if (flushed) begin
      repeat (8) begin
        @(negedge clk);
        if (if_done_o) n_done++;
      end
      check("flush_no_done", 32'(n_done), 32'h0);
      check("flush_data_held", if_data_o, last_if);
    end else begin
      check("fetch_done_seen", 32'(seen), 32'h1);
      check("fetch_latency", 32'(cnt), 32'(exp_lat));
      check("fetch_data", if_data_o, exp_w);
      check("fetch_no_mem_done", 32'(mem_done_o), 32'h0);
      last_if = exp_w;
      buf_v = 1'b1;
      buf_a = a;
    end
    if_req_i = 1'b0;
  endtask

  // driver: one load or store
  task automatic do_mem(input bit we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    int cnt, n, exp_lat;
    bit seen;
    logic [31:0] exp_r;
    n = len_bytes(len);
    exp_lat = we ? n + 2 : n + 3;
    exp_r = ref_word(a, n);
    cnt = 0; seen = 1'b0;
    @(posedge clk); #1;
    mem_we_i = we; mem_len_i = len; mem_addr_i = a; mem_wdata_i = wd; mem_req_i = 1'b1;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      check("stall", 32'(stallreq_o), 32'(cnt != exp_lat));
      if (cnt >= 2 && cnt <= n + 1) begin
        check("mem_ram_a", 32'(ram_a_o), (a + 32'(cnt - 2)) & MASK);
        check("mem_ram_wr", 32'(ram_wr_o), 32'(we));
        if (we) check("mem_ram_dout", 32'(ram_dout_o), 32'(wd[8*(cnt-2) +: 8]));
      end
      if (we && cnt == n + 2) check("wr_low_in_done", 32'(ram_wr_o), 32'h0);
      if (mem_done_o) seen = 1'b1;
    end
    check("mem_done_seen", 32'(seen), 32'h1);
    check("mem_latency", 32'(cnt), 32'(exp_lat));
    check("mem_no_if_done", 32'(if_done_o), 32'h0);
    if (we) begin
      check("store_rdata_held", mem_rdata_o, last_mem);
      for (int i = 0; i < n; i++) ref_mem[ADDR_W'(a + 32'(i))] = wd[8*i +: 8];
      buf_v = 1'b0;
    end else begin
      check("load_data", mem_rdata_o, exp_r);
      last_mem = exp_r;
    end
    mem_req_i = 1'b0;
  endtask

  // driver: fetch and half-word load raised together; MEM must go first
  task automatic do_both(input logic [31:0] a_if, input logic [31:0] a_mem);
    int cnt, mem_cnt, if_cnt, exp_if;
    bit hit;
    logic [31:0] exp_w, exp_r;
    hit = 1'b0;
`ifdef MEM_CTRL_FETCH_BUF_EN
    hit = buf_v && (buf_a == a_if);
`endif
    exp_if = hit ? 7 : 12;
    exp_w = ref_word(a_if, 4);
    exp_r = ref_word(a_mem, 2);
    cnt = 0; mem_cnt = 0; if_cnt = 0;
    @(posedge clk); #1;
    if_addr_i = a_if; if_req_i = 1'b1;
    mem_we_i = 1'b0; mem_len_i = 2'd1; mem_addr_i = a_mem; mem_req_i = 1'b1;
    while (if_cnt == 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      check("both_stall", 32'(stallreq_o), 32'(cnt < 5));
      if (mem_done_o && mem_cnt == 0) begin
        mem_cnt = cnt;
        mem_req_i = 1'b0;
      end
      if (if_done_o) if_cnt = cnt;
    end
    mem_req_i = 1'b0;
    if_req_i = 1'b0;
    check("both_mem_latency", 32'(mem_cnt), 32'd5);
    check("both_if_latency", 32'(if_cnt), 32'(exp_if));
    check("both_mem_data", mem_rdata_o, exp_r);
    check("both_if_data", if_data_o, exp_w);
    last_mem = exp_r;
    last_if = exp_w;
    buf_v = 1'b1;
    buf_a = a_if;
  endtask

  initial begin
    int kind, fa;
    logic [31:0] a, w;
    logic [1:0] len;
    for (int i = 0; i < MSIZE; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h13; ref_mem[1] = 8'h00; ref_mem[2] = 8'h00; ref_mem[3] = 8'h00;
    rst = 1'b1;
    load_ram = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    load_ram = 1'b0;

    do_fetch(32'h0, 0);
    check("plan_first_fetch", if_data_o, 32'h00000013);
    do_mem(1'b1, 2'd3, 32'h100, 32'hDEADBEEF);
    do_mem(1'b0, 2'd0, 32'h102, 32'h0);
    check("plan_load_byte", mem_rdata_o, 32'h000000AD);
    do_both(32'h8, 32'h100);
    check("plan_load_half", mem_rdata_o, 32'h0000BEEF);
    do_fetch(32'h40, 4);
    do_fetch(32'h80, 0);
    do_mem(1'b0, 2'd3, 32'h1FFFE, 32'h0);
    do_fetch(32'h80, 0);
    do_mem(1'b1, 2'd0, 32'h200, $urandom);
    do_fetch(32'h80, 0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'h1FFF0 + 32'($urandom_range(0, 31));
      len = 2'($urandom_range(0, 3));
      w = $urandom;
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0;
          1:       a = 32'h80;
          2:       a = 32'h8001FFFE;
          default: a = 32'hFFFF0080;
        endcase
        fa = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 6) : 0;
        do_fetch(a, fa);
      end else begin
        do_mem(kind == 2, len, a, w);
      end
    end

    // reset in the middle of a word store: only bytes 0 and 1 reach the RAM
    a = 32'h300;
    w = $urandom;
    @(posedge clk); #1;
    mem_we_i = 1'b1; mem_len_i = 2'd3; mem_addr_i = a; mem_wdata_i = w; mem_req_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_req_i = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[ADDR_W'(a)] = w[7:0];
    ref_mem[ADDR_W'(a + 32'd1)] = w[15:8];
    buf_v = 1'b0;
    last_if = '0;
    last_mem = '0;
    do_mem(1'b0, 2'd3, a, 32'h0);
    do_fetch(32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
